// File: rtl/adlc_pkg.sv
// Shared definitions for the ADLC loop-select controller: state codes and
// a helper that sizes saturating counters.
package adlc_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        MEDIUM = 2'd2,
        FINE   = 2'd3
    } adlc_state_e;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adlc_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable; flags when
// it sits at its terminal value.
module adlc_sat_cnt
    import adlc_pkg::*;
#(
    parameter int MAX_VAL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int CW = cnt_width(MAX_VAL);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == CW'(MAX_VAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/adlc_mode_ctrl.sv
// Coarse/medium/fine regulation-loop selector for the digital LDO: picks one
// loop from the load-current sample with hysteresis, dwell and acquisition timeout.
module adlc_mode_ctrl
    import adlc_pkg::*;
#(
    parameter int W           = 8,
    parameter int HYST        = 4,
    parameter int DWELL_CYC   = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load_change,
    input  logic [W-1:0]    load_current,
    input  logic [W-1:0]    thr_coarse,
    input  logic [W-1:0]    thr_medium,
    output logic            coarse_loop,
    output logic            medium_loop,
    output logic            fine_loop,
    output logic [ST_W-1:0] state_o,
    output logic            settled,
    output logic            timeout_err
);

    localparam logic [W:0] HYST_EXT = (W + 1)'(HYST);

    adlc_state_e state_q, state_d, step_next;
    logic        acquiring_q, acquiring_d;
    logic        err_q, err_d;
    logic        restart;
    logic        dwell_done, dwell_clr;
    logic        acq_at_max, acq_clr;
    logic        step_pending;

    // Upward thresholds carry an extra bit so a large threshold blocks the step
    // instead of wrapping to a small value.
    logic [W:0] cur_ext, up_coarse, up_medium;
    logic       above_coarse, above_medium, below_coarse, below_medium;

    assign cur_ext      = {1'b0, load_current};
    assign up_coarse    = {1'b0, thr_coarse} + HYST_EXT;
    assign up_medium    = {1'b0, thr_medium} + HYST_EXT;
    assign above_coarse = (cur_ext >= up_coarse);
    assign above_medium = (cur_ext >= up_medium);
    assign below_coarse = (load_current < thr_coarse);
    assign below_medium = (load_current < thr_medium);

    assign restart = en && load_change;

    // Threshold-driven step target, one level at a time; the MEDIUM down-check wins.
    always_comb begin
        step_next = state_q;
        case (state_q)
            IDLE:    step_next = IDLE;
            COARSE:  if (above_coarse) step_next = MEDIUM;
            MEDIUM: begin
                if (below_coarse)      step_next = COARSE;
                else if (above_medium) step_next = FINE;
            end
            FINE:    if (below_medium) step_next = MEDIUM;
            default: step_next = IDLE;
        endcase
    end

    assign step_pending = (step_next != state_q);
    assign settled      = (state_q != IDLE) && dwell_done && !step_pending;

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (load_change) begin
            state_d = COARSE;
        end else if (dwell_done || (step_next == IDLE)) begin
            state_d = step_next;
        end
    end

    always_comb begin
        acquiring_d = acquiring_q;
        err_d       = err_q;
        if (!en) begin
            acquiring_d = 1'b0;
            err_d       = 1'b0;
        end else if (load_change) begin
            acquiring_d = 1'b1;
            err_d       = 1'b0;
        end else if (acquiring_q) begin
            if (settled) begin
                acquiring_d = 1'b0;
            end else if (acq_at_max) begin
                acquiring_d = 1'b0;
                err_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acquiring_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acquiring_q <= acquiring_d;
            err_q       <= err_d;
        end
    end

    // A restart into COARSE from COARSE is not a state change but still restarts the dwell.
    assign dwell_clr = (state_d != state_q) || restart || !en;
    assign acq_clr   = restart || !en;

    adlc_sat_cnt #(.MAX_VAL(DWELL_CYC - 1)) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (dwell_clr),
        .en     (1'b1),
        .at_max (dwell_done)
    );

    adlc_sat_cnt #(.MAX_VAL(TIMEOUT_CYC - 1)) u_acq_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acq_clr),
        .en     (acquiring_q),
        .at_max (acq_at_max)
    );

    assign state_o     = state_q;
    assign coarse_loop = (state_q == COARSE);
    assign medium_loop = (state_q == MEDIUM);
    assign fine_loop   = (state_q == FINE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_adlc_mode_ctrl.sv
// Bench for adlc_mode_ctrl: directed scenarios plus random stimulus, every
// cycle compared with a level/age reference model kept here.
module tb_adlc_mode_ctrl;

    localparam int W           = 8;
    localparam int HYST        = 4;
    localparam int DWELL_CYC   = 4;
    localparam int TIMEOUT_CYC = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         load_change;
    logic [W-1:0] load_current;
    logic [W-1:0] thr_coarse;
    logic [W-1:0] thr_medium;
    logic         coarse_loop;
    logic         medium_loop;
    logic         fine_loop;
    logic [1:0]   state_o;
    logic         settled;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: loop level 0..3, time spent at that level, acquisition age.
    int m_lvl   = 0;
    int m_dwell = 0;
    int m_age   = 0;
    bit m_acq   = 0;
    bit m_err   = 0;

    adlc_mode_ctrl #(
        .W(W), .HYST(HYST), .DWELL_CYC(DWELL_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load_change  (load_change),
        .load_current (load_current),
        .thr_coarse   (thr_coarse),
        .thr_medium   (thr_medium),
        .coarse_loop  (coarse_loop),
        .medium_loop  (medium_loop),
        .fine_loop    (fine_loop),
        .state_o      (state_o),
        .settled      (settled),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Level the thresholds ask for from the given level, at most one step away.
    function automatic int wantLevel(input int lvl, input int cur, input int tc, input int tm);
        case (lvl)
            1:       return (cur >= tc + HYST) ? 2 : 1;
            2:       return (cur < tc) ? 1 : ((cur >= tm + HYST) ? 3 : 2);
            3:       return (cur < tm) ? 2 : 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit modelSettled(input int cur, input int tc, input int tm);
        return (m_lvl != 0) && (m_dwell >= DWELL_CYC - 1) &&
               (wantLevel(m_lvl, cur, tc, tm) == m_lvl);
    endfunction

    task automatic modelReset();
        m_lvl = 0; m_dwell = 0; m_age = 0; m_acq = 0; m_err = 0;
    endtask

    task automatic modelClock(input bit e, input bit lc, input int cur, input int tc, input int tm);
        int  nxt;
        bit  set;
        set = modelSettled(cur, tc, tm);
        if (!e) begin
            modelReset();
        end else if (lc) begin
            m_lvl = 1; m_dwell = 0; m_age = 0; m_acq = 1; m_err = 0;
        end else begin
            nxt = (m_dwell >= DWELL_CYC - 1) ? wantLevel(m_lvl, cur, tc, tm) : m_lvl;
            if (m_acq) begin
                if (set) m_acq = 0;
                else if (m_age == TIMEOUT_CYC - 1) begin
                    m_err = 1;
                    m_acq = 0;
                end else m_age++;
            end
            if (nxt != m_lvl) m_dwell = 0;
            else if (m_dwell < DWELL_CYC - 1) m_dwell++;
            m_lvl = nxt;
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance the model on the rising edge.
    task automatic applyStimulus(input bit e, input bit lc, input int cur, input int tc, input int tm);
        int exp_loops;
        @(negedge clk);
        en           = e;
        load_change  = lc;
        load_current = W'(cur);
        thr_coarse   = W'(tc);
        thr_medium   = W'(tm);
        #1;
        exp_loops = (m_lvl == 0) ? 0 : (1 << (m_lvl - 1));
        checkOutput("state", int'(state_o), m_lvl);
        checkOutput("loops", int'({fine_loop, medium_loop, coarse_loop}), exp_loops);
        checkOutput("settled", int'(settled), int'(modelSettled(cur, tc, tm)));
        checkOutput("timeout_err", int'(timeout_err), int'(m_err));
        @(posedge clk);
        modelClock(e, lc, cur, tc, tm);
    endtask

    task automatic expectState(input string tag, input int lvl);
        #1;
        checkOutput(tag, int'(state_o), lvl);
    endtask

    task automatic holdLoad(input int n, input int cur, input int tc, input int tm);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, cur, tc, tm);
    endtask

    initial begin
        int tc, tm, cur, hold_val;
        bit hold_mode;

        rst_n = 1'b0; en = 1'b0; load_change = 1'b0;
        load_current = '0; thr_coarse = 8'd64; thr_medium = 8'd160;
        #12;
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_outputs", int'({coarse_loop, medium_loop, fine_loop, settled, timeout_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        holdLoad(2, 200, 64, 160);
        expectState("idle_without_restart", 0);

        // Ramp up through every level on a heavy load.
        applyStimulus(1'b1, 1'b1, 200, 64, 160);
        expectState("ramp_coarse", 1);
        holdLoad(4, 200, 64, 160);
        expectState("ramp_medium", 2);
        holdLoad(7, 200, 64, 160);
        expectState("ramp_fine", 3);
        checkOutput("ramp_settled", int'(settled), 1);

        // Hysteresis around the medium/fine boundary.
        holdLoad(1, 159, 64, 160);
        expectState("hyst_drop_medium", 2);
        holdLoad(6, 163, 64, 160);
        expectState("hyst_hold_medium", 2);
        holdLoad(1, 164, 64, 160);
        expectState("hyst_step_fine", 3);
        holdLoad(6, 160, 64, 160);
        expectState("hyst_hold_fine", 3);
        checkOutput("hyst_fine_settled", int'(settled), 1);

        // Restart from FINE, then disable together with a restart.
        applyStimulus(1'b1, 1'b1, 200, 64, 160);
        expectState("restart_coarse", 1);
        checkOutput("restart_err_clear", int'(timeout_err), 0);
        applyStimulus(1'b0, 1'b1, 200, 64, 160);
        expectState("disable_idle", 0);

        // Asynchronous reset while in FINE.
        applyStimulus(1'b1, 1'b1, 200, 64, 160);
        holdLoad(11, 200, 64, 160);
        expectState("pre_reset_fine", 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", int'(state_o), 0);
        checkOutput("async_rst_outputs", int'({coarse_loop, medium_loop, fine_loop, settled, timeout_err}), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        holdLoad(1, 200, 64, 160);
        expectState("post_reset_idle", 0);

        // Load that keeps bouncing COARSE<->MEDIUM never settles and times out.
        applyStimulus(1'b1, 1'b1, 200, 64, 160);
        for (int i = 0; i < TIMEOUT_CYC; i++)
            applyStimulus(1'b1, 1'b0, (m_lvl == 1) ? 200 : 10, 64, 160);
        #1;
        checkOutput("timeout_set", int'(timeout_err), 1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, (m_lvl == 1) ? 200 : 10, 64, 160);
        #1;
        checkOutput("timeout_sticky", int'(timeout_err), 1);
        applyStimulus(1'b1, 1'b1, 200, 64, 160);
        #1;
        checkOutput("timeout_cleared", int'(timeout_err), 0);

        // Medium/fine threshold so high the hysteresis sum exceeds full scale.
        applyStimulus(1'b1, 1'b1, 255, 64, 254);
        holdLoad(20, 255, 64, 254);
        expectState("overflow_medium", 2);
        checkOutput("overflow_settled", int'(settled), 1);

        // Swapped thresholds.
        applyStimulus(1'b1, 1'b1, 75, 100, 50);
        holdLoad(10, 75, 100, 50);
        expectState("misconfig_hold_coarse", 1);

        // Random traffic with occasional retrims, restarts and disables.
        tc = 64; tm = 160; hold_mode = 0; hold_val = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                tc = $urandom_range(0, 255);
                tm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                 : clip(tc + $urandom_range(0, 120));
            end
            if (cyc % 40 == 0) begin
                hold_mode = $urandom_range(0, 1);
                hold_val  = $urandom_range(0, 255);
            end
            case ($urandom_range(0, 3))
                0:       cur = clip(tc + $urandom_range(0, 16) - 8);
                1:       cur = clip(tm + $urandom_range(0, 16) - 8);
                2:       cur = clip(tm + HYST + $urandom_range(0, 4) - 2);
                default: cur = $urandom_range(0, 255);
            endcase
            if (hold_mode) cur = hold_val;
            applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0), cur, tc, tm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
